// File: rtl/fpu_issue_queue_if.sv
// fpu_issue_queue_if: signal bundle for the FPU issue queue.
//   Command side : in_valid/in_ready handshake carrying din1, din2, op_sel.
//   FPU side     : fpu_valid issue pulse with fpu_din1/fpu_din2/fpu_op_sel;
//                  fpu_ready result pulse with fpu_result.
//   Result side  : out_valid/out_ready handshake carrying result.
//   Status       : inflight count, sticky err_unexpected.
// The slave modport is the queue's view; master is the environment's view.
interface fpu_issue_queue_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned OP_W      = 2,
    parameter int unsigned RES_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(RES_DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic [OP_W-1:0]  op_sel;
    logic             fpu_valid;
    logic [WIDTH-1:0] fpu_din1;
    logic [WIDTH-1:0] fpu_din2;
    logic [OP_W-1:0]  fpu_op_sel;
    logic [WIDTH-1:0] fpu_result;
    logic             fpu_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] inflight;
    logic             err_unexpected;

    modport master (
        output in_valid, din1, din2, op_sel, fpu_result, fpu_ready, out_ready,
        input  in_ready, fpu_valid, fpu_din1, fpu_din2, fpu_op_sel, out_valid, result,
               inflight, err_unexpected
    );

    modport slave (
        input  in_valid, din1, din2, op_sel, fpu_result, fpu_ready, out_ready,
        output in_ready, fpu_valid, fpu_din1, fpu_din2, fpu_op_sel, out_valid, result,
               inflight, err_unexpected
    );
endinterface

// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: command/result buffering front-end for a pipelined, in-order FPU.
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : fpu_issue_queue_if.slave
//            - commands are queued in a CMD_DEPTH FIFO and issued one per cycle as a
//              registered one-cycle fpu_valid pulse with registered operands
//            - results returned by fpu_ready are buffered in a RES_DEPTH show-ahead FIFO
//            - issue is credit-gated so in-flight plus buffered results never exceed
//              RES_DEPTH, hence a returning result always has room
//            - err_unexpected latches a result pulse that arrives with nothing in flight
module fpu_issue_queue #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned OP_W      = 2,
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned RES_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    fpu_issue_queue_if.slave bus
);
    localparam int unsigned CIDX = $clog2(CMD_DEPTH);
    localparam int unsigned RIDX = $clog2(RES_DEPTH);
    localparam int unsigned CCNT = CIDX + 1;
    localparam int unsigned RCNT = RIDX + 1;
    localparam logic [CCNT-1:0] CMD_LIMIT = CCNT'(CMD_DEPTH);
    localparam logic [RCNT:0]   RES_LIMIT = (RCNT + 1)'(RES_DEPTH);

    logic [WIDTH-1:0] cmd_a_q  [CMD_DEPTH];
    logic [WIDTH-1:0] cmd_b_q  [CMD_DEPTH];
    logic [OP_W-1:0]  cmd_op_q [CMD_DEPTH];
    logic [CIDX-1:0]  cmd_wptr_q, cmd_rptr_q;
    logic [CCNT-1:0]  cmd_count_q;

    logic [WIDTH-1:0] res_mem_q [RES_DEPTH];
    logic [RIDX-1:0]  res_wptr_q, res_rptr_q;
    logic [RCNT-1:0]  res_count_q;
    logic [RCNT-1:0]  inflight_q;
    logic             err_q;

    logic             fpu_valid_q;
    logic [WIDTH-1:0] fpu_din1_q, fpu_din2_q;
    logic [OP_W-1:0]  fpu_op_sel_q;

    logic            cmd_ready;
    logic            cmd_push;
    logic            issue;
    logic            res_push;
    logic            res_pop;
    logic            unexpected;
    logic [RCNT:0]   credit_used;

    always_comb begin
        // Ready depends on count only, so a full FIFO refuses a push even while popping.
        cmd_ready   = cmd_count_q < CMD_LIMIT;
        cmd_push    = bus.in_valid && cmd_ready;
        credit_used = {1'b0, inflight_q} + {1'b0, res_count_q};
        issue       = (cmd_count_q != '0) && (credit_used < RES_LIMIT);
        res_push    = bus.fpu_ready && (inflight_q != '0);
        unexpected  = bus.fpu_ready && (inflight_q == '0);
        res_pop     = (res_count_q != '0) && bus.out_ready;
    end

    // Command storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_a_q[cmd_wptr_q]  <= bus.din1;
            cmd_b_q[cmd_wptr_q]  <= bus.din2;
            cmd_op_q[cmd_wptr_q] <= bus.op_sel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_wptr_q   <= '0;
            cmd_rptr_q   <= '0;
            cmd_count_q  <= '0;
            res_wptr_q   <= '0;
            res_rptr_q   <= '0;
            res_count_q  <= '0;
            inflight_q   <= '0;
            err_q        <= 1'b0;
            fpu_valid_q  <= 1'b0;
            fpu_din1_q   <= '0;
            fpu_din2_q   <= '0;
            fpu_op_sel_q <= '0;
            for (int i = 0; i < int'(RES_DEPTH); i++) begin
                res_mem_q[i] <= '0;
            end
        end else begin
            if (cmd_push) begin
                cmd_wptr_q <= cmd_wptr_q + CIDX'(1);
            end
            cmd_count_q <= cmd_count_q + CCNT'(cmd_push) - CCNT'(issue);

            fpu_valid_q <= issue;
            if (issue) begin
                fpu_din1_q   <= cmd_a_q[cmd_rptr_q];
                fpu_din2_q   <= cmd_b_q[cmd_rptr_q];
                fpu_op_sel_q <= cmd_op_q[cmd_rptr_q];
                cmd_rptr_q   <= cmd_rptr_q + CIDX'(1);
            end

            // Unexpected results are dropped, so inflight never underflows.
            inflight_q <= inflight_q + RCNT'(issue) - RCNT'(res_push);

            if (res_push) begin
                res_mem_q[res_wptr_q] <= bus.fpu_result;
                res_wptr_q            <= res_wptr_q + RIDX'(1);
            end
            if (res_pop) begin
                res_rptr_q <= res_rptr_q + RIDX'(1);
            end
            res_count_q <= res_count_q + RCNT'(res_push) - RCNT'(res_pop);

            if (unexpected) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready       = cmd_ready;
    assign bus.fpu_valid      = fpu_valid_q;
    assign bus.fpu_din1       = fpu_din1_q;
    assign bus.fpu_din2       = fpu_din2_q;
    assign bus.fpu_op_sel     = fpu_op_sel_q;
    assign bus.out_valid      = res_count_q != '0;
    assign bus.result         = res_mem_q[res_rptr_q];
    assign bus.inflight       = inflight_q;
    assign bus.err_unexpected = err_q;
endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb_fpu_issue_queue: self-checking bench for fpu_issue_queue.
//   A 3-cycle pipelined FPU model computes real single-precision results.
//   A transaction-level model (command, in-flight and result queues) predicts every
//   handshake and is compared against the DUT on each falling edge.
module tb_fpu_issue_queue;
    localparam int unsigned WIDTH     = 32;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned CMD_DEPTH = 4;
    localparam int unsigned RES_DEPTH = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fpu_issue_queue_if #(.WIDTH(WIDTH), .OP_W(OP_W), .RES_DEPTH(RES_DEPTH)) bus ();

    fpu_issue_queue #(
        .WIDTH    (WIDTH),
        .OP_W     (OP_W),
        .CMD_DEPTH(CMD_DEPTH),
        .RES_DEPTH(RES_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- single-precision arithmetic via double conversion (normal numbers only) ----
    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        logic [10:0] e;
        if (x[30:0] == '0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        d = {x[31], e, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == '0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        real x, y, r;
        x = sp2r(a);
        y = sp2r(b);
        case (op)
            2'd0:    r = x + y;
            2'd1:    r = x - y;
            2'd2:    r = x * y;
            default: r = y - x;
        endcase
        return r2sp(r);
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 14)), 23'($urandom)};
    endfunction

    // ---- FPU model: fixed latency 3, shares reset ----
    logic [3:0]  pipe_v = '0;
    logic [31:0] pipe_d [4];
    logic        force_ready = 1'b0;
    assign bus.fpu_ready  = pipe_v[3] | force_ready;
    assign bus.fpu_result = pipe_d[3];

    initial begin
        for (int i = 0; i < 4; i++) pipe_d[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                pipe_v = '0;
            end else begin
                for (int i = 3; i > 0; i--) begin
                    pipe_v[i] = pipe_v[i-1];
                    pipe_d[i] = pipe_d[i-1];
                end
                pipe_v[0] = bus.fpu_valid;
                pipe_d[0] = fpu_fn(bus.fpu_din1, bus.fpu_din2, bus.fpu_op_sel);
            end
        end
    end

    // ---- transaction-level reference model ----
    cmd_t        cmd_q[$];
    logic [31:0] fly_q[$];
    logic [31:0] res_q[$];
    bit          exp_issue = 1'b0;
    bit          exp_err   = 1'b0;
    cmd_t        last_issue;
    int          issued = 0;
    int          popped = 0;

    initial begin
        bit cap, iss, pop, push;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cmd_q.delete();
                fly_q.delete();
                res_q.delete();
                exp_issue = 1'b0;
                exp_err   = 1'b0;
            end else begin
                check("in_ready", bus.in_ready, cmd_q.size() < CMD_DEPTH);
                check("out_valid", bus.out_valid, res_q.size() != 0);
                if (res_q.size() != 0) check("result", bus.result, res_q[0]);
                check("inflight", bus.inflight, fly_q.size());
                check("err_unexpected", bus.err_unexpected, exp_err);
                check("fpu_valid", bus.fpu_valid, exp_issue);
                if (exp_issue) begin
                    check("fpu_din1", bus.fpu_din1, last_issue.a);
                    check("fpu_din2", bus.fpu_din2, last_issue.b);
                    check("fpu_op_sel", bus.fpu_op_sel, last_issue.op);
                end
                // Predict what the coming rising edge does.
                cap  = bus.fpu_ready && fly_q.size() != 0;
                iss  = cmd_q.size() != 0 && (fly_q.size() + res_q.size() < RES_DEPTH);
                pop  = res_q.size() != 0 && bus.out_ready;
                push = bus.in_valid && cmd_q.size() < CMD_DEPTH;
                if (bus.fpu_ready && fly_q.size() == 0) exp_err = 1'b1;
                if (pop) begin
                    void'(res_q.pop_front());
                    popped++;
                end
                if (cap) res_q.push_back(fly_q.pop_front());
                if (iss) begin
                    last_issue = cmd_q.pop_front();
                    fly_q.push_back(fpu_fn(last_issue.a, last_issue.b, last_issue.op));
                    issued++;
                end
                if (push) cmd_q.push_back('{a: bus.din1, b: bus.din2, op: bus.op_sel});
                exp_issue = iss;
            end
        end
    end

    // ---- stimulus helpers (called at posedge+1) ----
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.din1     = a;
        bus.din2     = b;
        bus.op_sel   = op;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input int limit);
        bit done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(posedge clk);
            #1;
            done = (cmd_q.size() == 0) && (fly_q.size() == 0) && (res_q.size() == 0);
        end
        if (!done) check("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic single_op(input string tag);
        bit seen = 1'b0;
        bus.out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 2'd0);
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        check({tag, "_out_valid"}, bus.out_valid, 1);
        check({tag, "_result"}, bus.result, 32'h40400000);
        check({tag, "_inflight"}, bus.inflight, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_drained(50);
    endtask

    initial begin
        int base_i, base_p;
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
        base_i = 0;
        base_p = 0;
    end

    initial begin
        int base_i, base_p;
        bus.in_valid  = 1'b1;
        bus.din1      = '0;
        bus.din2      = '0;
        bus.op_sel    = '0;
        bus.out_ready = 1'b0;

        // Reset with in_valid held high.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_fpu_valid", bus.fpu_valid, 0);
        check("rst_inflight", bus.inflight, 0);
        check("rst_err", bus.err_unexpected, 0);
        check("rst_result", bus.result, 0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        wait_cycles(2);

        // Single op 1.0 + 2.0.
        single_op("single");

        // Six back-to-back ops with a free-running consumer.
        bus.out_ready = 1'b1;
        base_p = popped;
        for (int i = 0; i < 6; i++) send(rand_fp(), rand_fp(), 2'(i));
        wait_drained(100);
        check("six_results", popped - base_p, 6);

        // Backpressure: eight ops, consumer stalled.
        bus.out_ready = 1'b0;
        base_i = issued;
        base_p = popped;
        for (int i = 0; i < 8; i++) send(rand_fp(), rand_fp(), 2'($urandom_range(0, 3)));
        wait_cycles(20);
        check("stall_issues", issued - base_i, 4);
        check("stall_inflight", bus.inflight, 0);
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_cmd_full", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        wait_drained(100);
        check("stall_drained", popped - base_p, 8);

        // Unexpected result pulse while idle.
        wait_cycles(2);
        force_ready = 1'b1;
        wait_cycles(1);
        force_ready = 1'b0;
        wait_cycles(3);
        check("err_sticky", bus.err_unexpected, 1);
        check("err_no_result", bus.out_valid, 0);
        reset = 1'b0;
        #1;
        check("err_cleared", bus.err_unexpected, 0);
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(1);

        // Asynchronous reset with work queued and in flight.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(rand_fp(), rand_fp(), 2'($urandom_range(0, 3)));
        check("pre_rst_busy", (bus.inflight != 0) || bus.out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_inflight", bus.inflight, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_fpu_valid", bus.fpu_valid, 0);
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(1);
        single_op("post_rst");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.din1      = rand_fp();
            bus.din2      = rand_fp();
            bus.op_sel    = 2'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            wait_cycles(1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drained(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpu_issue_queue.md
Name: fpu_issue_queue

Overview:
Parametrised command/result buffering front-end for the FPU core. It accepts operand pairs and an op select over a valid/ready handshake and queues them in a command FIFO. Each queued op is issued to a pipelined FPU as a one-cycle valid pulse. Completed results are captured in order into a result FIFO and returned over a second valid/ready handshake, with credit control so that no result is ever dropped under downstream backpressure.

Parameters:
WIDTH, 32, operand/result width in bits
OP_W, 2, op_sel width
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RES_DEPTH, 4, result FIFO entries (power of 2, >=2); also the maximum of in-flight plus buffered results

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  command present
in_ready  out  1  command FIFO can accept
din1  in  WIDTH  operand A
din2  in  WIDTH  operand B
op_sel  in  OP_W  operation select
fpu_valid  out  1  one-cycle issue pulse to FPU
fpu_din1  out  WIDTH  issued operand A
fpu_din2  out  WIDTH  issued operand B
fpu_op_sel  out  OP_W  issued op
fpu_result  in  WIDTH  FPU result
fpu_ready  in  1  FPU result-valid pulse; results arrive in issue order
out_valid  out  1  result FIFO non-empty
out_ready  in  1  consumer accepts result
result  out  WIDTH  head of result FIFO (show-ahead)
inflight  out  $clog2(RES_DEPTH)+1  ops issued but not yet returned
err_unexpected  out  1  sticky flag: fpu_ready seen with inflight==0

Behaviour:
- Reset (reset==0, asynchronous): both FIFOs empty; all pointers and counters are 0. Outputs: in_ready=1, fpu_valid=0, fpu_din1/fpu_din2/fpu_op_sel=0, out_valid=0, result=0, inflight=0, err_unexpected=0. Reset release is synchronous to clk.
- Command push: in_valid && in_ready at a rising edge writes {din1,din2,op_sel}. in_ready = (cmd_count < CMD_DEPTH), derived from count only. A full FIFO rejects a push even in a cycle where it pops.
- Issue condition at each edge: cmd FIFO non-empty && (inflight + res_count < RES_DEPTH). When it holds, the head is popped and fpu_valid/fpu_din1/fpu_din2/fpu_op_sel are registered, so fpu_valid is high for exactly one cycle per op. Otherwise fpu_valid=0 and the fpu_* data hold their last values. Back-to-back issue at one op per cycle is allowed.
- Minimum latency: command accepted at edge N is issued (fpu_valid high) after edge N+1.
- inflight: +1 on issue, -1 on fpu_ready, unchanged when both happen in the same cycle. It never exceeds RES_DEPTH.
- Result capture: fpu_ready pushes fpu_result into the result FIFO. The credit rule guarantees space. If inflight==0, err_unexpected is set (sticky until reset), the data is dropped, and inflight stays at 0.
- Result pop: out_valid = res_count != 0. result always shows the head entry. out_valid && out_ready pops. A push and a pop in the same cycle are both honoured and res_count is unchanged.
- Ordering: results leave in command order (the FPU is in-order).
- Pointers wrap modulo depth. Counts are one bit wider than the index.
- Reset mid-operation: all queued, in-flight and buffered state is discarded. The FPU shares the same reset.

Test Plan:
- Reset with in_valid=1 → in_ready=1, out_valid=0, fpu_valid=0, inflight=0, err_unexpected=0.
- Single op din1=0x3F800000, din2=0x40000000, op_sel=0 accepted at edge 0 → fpu_valid high after edge 1 with those operands. FPU model (latency 3) returns 0x40400000 → out_valid=1, result=0x40400000, inflight back to 0.
- Push 6 ops back-to-back with out_ready=1, CMD_DEPTH=4, FPU latency 3 → in_ready drops only while cmd_count==4. Six results appear in push order, each one equal to its op.
- out_ready=0, push 8 ops → exactly 4 fpu_valid pulses, then issue stalls with inflight+res_count==4 and no result is lost. Raising out_ready drains all 8 in order.
- Pulse fpu_ready with inflight==0 → err_unexpected=1 and stays set, result FIFO unchanged. Asserting reset clears the flag.
- Assert reset with 3 ops queued and 2 in flight → all counts 0 immediately (asynchronous). After release, new ops behave as in the second scenario.
